simon_fsm_multi: RTL and testbench



---
 rtl/simon_fsm_multi.sv | 198 +++++++++++++++++++
 tb/tb_simon_fsm_multi.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_fsm_multi.sv
// Simon game controller with a configurable number of colours and sequence depth.
// On every new game the stored sequence is loaded from the LFSR. The controller
// then plays back a growing prefix of the sequence on one-hot LEDs and checks
// the player's presses against it. Completing MAX_LEN rounds wins the game.
// Optional build macro SIMON_TIMEOUT_EN: when defined, the player must press a
// button within TIMEOUT_TICKS cycles while in WAIT. Otherwise WAIT waits forever.
module simon_fsm_multi #(
   parameter int NUM_COLORS    = 4,
   parameter int MAX_LEN       = 10,
   parameter int ON_TICKS      = 3,
   parameter int OFF_TICKS     = 2,
   parameter int TIMEOUT_TICKS = 50,
   localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
   localparam int RW = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk_tick,
   input  logic                  reset_n,
   input  logic [CW-1:0]         rnd_val,
   input  logic                  btn_valid,
   input  logic [CW-1:0]         btn_val,
   output logic                  lfsr_enable,
   output logic [NUM_COLORS-1:0] led,
   output logic                  error_led,
   output logic                  win_led,
   output logic [RW-1:0]         round,
   output logic [2:0]            state
);

   // Memory address width; counters carry RW bits and are sliced down to this.
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   // The timer is shared by the LED phases and the input timeout.
   localparam int TMAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TMAX  = (TMAX0 > TIMEOUT_TICKS) ? TMAX0 : TIMEOUT_TICKS;
   localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [RW-1:0]         R_ONE     = RW'(1);
   localparam logic [RW-1:0]         R_MAX     = RW'(MAX_LEN);
   localparam logic [TW-1:0]         T_ONE     = TW'(1);
   localparam logic [TW-1:0]         T_ON_END  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0]         T_OFF_END = TW'(OFF_TICKS - 1);
`ifdef SIMON_TIMEOUT_EN
   localparam logic [TW-1:0]         T_TO_END  = TW'(TIMEOUT_TICKS - 1);
`endif
   localparam logic [NUM_COLORS-1:0] LED_ONE   = NUM_COLORS'(1);

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_SHOW_ON  = 3'd1,
      S_SHOW_OFF = 3'd2,
      S_WAIT     = 3'd3,
      S_ERROR    = 3'd4,
      S_WIN      = 3'd5
   } state_t;

   state_t        st;
   logic [RW-1:0] idx;
   logic [RW-1:0] play_idx;
   logic [RW-1:0] input_idx;
   logic [TW-1:0] timer;

   logic [CW-1:0] mem [MAX_LEN];
   logic          mem_we;
   logic [CW-1:0] mem_first;
   logic [CW-1:0] mem_play_nxt;
   logic [CW-1:0] mem_input;

   function automatic logic [NUM_COLORS-1:0] onehot(input logic [CW-1:0] c);
      return LED_ONE << c;
   endfunction

   assign state        = st;
   assign mem_we       = (st == S_INIT) && (idx < R_MAX);
   assign mem_first    = mem[0];
   assign mem_play_nxt = mem[AW'(play_idx + R_ONE)];
   assign mem_input    = mem[input_idx[AW-1:0]];

   // Sequence storage: written only while loading, never reset.
   always_ff @(posedge clk_tick) begin
      if (mem_we) mem[idx[AW-1:0]] <= rnd_val;
   end

   // Game FSM with registered outputs.
   always_ff @(posedge clk_tick or negedge reset_n) begin
      if (!reset_n) begin
         st          <= S_INIT;
         led         <= '0;
         error_led   <= 1'b0;
         win_led     <= 1'b0;
         round       <= '0;
         lfsr_enable <= 1'b0;
         idx         <= '0;
         play_idx    <= '0;
         input_idx   <= '0;
         timer       <= '0;
      end else begin
         lfsr_enable <= 1'b0;
         case (st)
            S_INIT: begin
               if (idx < R_MAX) begin
                  lfsr_enable <= 1'b1;
                  idx         <= idx + R_ONE;
               end else begin
                  round    <= R_ONE;
                  play_idx <= '0;
                  timer    <= '0;
                  led      <= onehot(mem_first);
                  st       <= S_SHOW_ON;
               end
            end
            S_SHOW_ON: begin
               if (timer == T_ON_END) begin
                  led   <= '0;
                  timer <= '0;
                  st    <= S_SHOW_OFF;
               end else begin
                  timer <= timer + T_ONE;
               end
            end
            S_SHOW_OFF: begin
               if (timer == T_OFF_END) begin
                  timer <= '0;
                  if (play_idx + R_ONE == round) begin
                     input_idx <= '0;
                     st        <= S_WAIT;
                  end else begin
                     play_idx <= play_idx + R_ONE;
                     led      <= onehot(mem_play_nxt);
                     st       <= S_SHOW_ON;
                  end
               end else begin
                  timer <= timer + T_ONE;
               end
            end
            S_WAIT: begin
               if (btn_valid) begin
                  if (btn_val == mem_input) begin
                     if (input_idx + R_ONE == round) begin
                        if (round == R_MAX) begin
                           win_led <= 1'b1;
                           st      <= S_WIN;
                        end else begin
                           round    <= round + R_ONE;
                           play_idx <= '0;
                           timer    <= '0;
                           led      <= onehot(mem_first);
                           st       <= S_SHOW_ON;
                        end
                     end else begin
                        input_idx <= input_idx + R_ONE;
                        timer     <= '0;
                     end
                  end else begin
                     error_led <= 1'b1;
                     st        <= S_ERROR;
                  end
               end
`ifdef SIMON_TIMEOUT_EN
               else if (timer == T_TO_END) begin
                  error_led <= 1'b1;
                  st        <= S_ERROR;
               end else begin
                  timer <= timer + T_ONE;
               end
`endif
            end
            S_ERROR: begin
               if (btn_valid) begin
                  error_led <= 1'b0;
                  round     <= R_ONE;
                  play_idx  <= '0;
                  timer     <= '0;
                  led       <= onehot(mem_first);
                  st        <= S_SHOW_ON;
               end
            end
            S_WIN: begin
               if (btn_valid) begin
                  win_led <= 1'b0;
                  idx     <= '0;
                  round   <= '0;
                  st      <= S_INIT;
               end
            end
            default: begin
               // Unused codes fall back to a clean reload.
               st        <= S_INIT;
               idx       <= '0;
               round     <= '0;
               timer     <= '0;
               led       <= '0;
               error_led <= 1'b0;
               win_led   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_fsm_multi.sv
// Bench for simon_fsm_multi: small game configuration, scripted LFSR values
// followed by random ones, and random button noise during playback.
module tb_simon_fsm_multi;

   localparam int NC  = 4;
   localparam int ML  = 4;
   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int TO  = 10;
   localparam int CW  = 2;
   localparam int RW  = 3;
   localparam int STEP = ON + OFF;

   logic          clk_tick = 1'b0;
   logic          reset_n  = 1'b0;
   logic [CW-1:0] rnd_val  = '0;
   logic          btn_valid = 1'b0;
   logic [CW-1:0] btn_val  = '0;
   logic          lfsr_enable;
   logic [NC-1:0] led;
   logic          error_led;
   logic          win_led;
   logic [RW-1:0] round;
   logic [2:0]    state;

   simon_fsm_multi #(
      .NUM_COLORS(NC), .MAX_LEN(ML), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO)
   ) dut (
      .clk_tick(clk_tick), .reset_n(reset_n), .rnd_val(rnd_val),
      .btn_valid(btn_valid), .btn_val(btn_val), .lfsr_enable(lfsr_enable),
      .led(led), .error_led(error_led), .win_led(win_led),
      .round(round), .state(state)
   );

   always #5 clk_tick = ~clk_tick;

   int n_checks = 0;
   int n_fail   = 0;

   // External LFSR model: a table of values, advanced once per enable cycle.
   logic [CW-1:0] rq [256];
   int            rptr = 0;
   int            seq [ML];
   logic [NC-1:0] cap_q [$];
   logic [NC-1:0] exp_q [$];

   always @(negedge clk_tick) begin
      if (lfsr_enable === 1'b1) begin
         rptr    = (rptr + 1) % 256;
         rnd_val = rq[rptr];
      end
   end

   // Expected game sequence: the next ML values the LFSR will present.
   function automatic void load_seq(input int p0);
      for (int i = 0; i < ML; i++) seq[i] = int'(rq[(p0 + i) % 256]);
   endfunction

   // Expected LED trace for playback of round r.
   function automatic void build_exp(input int r);
      logic [NC-1:0] v;
      exp_q.delete();
      for (int i = 0; i < r; i++) begin
         v = '0;
         v[seq[i]] = 1'b1;
         for (int k = 0; k < ON; k++)  exp_q.push_back(v);
         for (int k = 0; k < OFF; k++) exp_q.push_back('0);
      end
   endfunction

   // Index of first difference between captured and expected traces, -1 if equal.
   function automatic int trace_diff();
      if (cap_q.size() != exp_q.size()) return 0;
      for (int i = 0; i < cap_q.size(); i++)
         if (cap_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic capture(input int n, input bit noisy);
      cap_q.delete();
      for (int k = 0; k < n; k++) begin
         cap_q.push_back(led);
         if (noisy) begin
            btn_valid = 1'($urandom_range(0, 1));
            btn_val   = CW'($urandom_range(0, NC - 1));
         end
         @(negedge clk_tick);
      end
      btn_valid = 1'b0;
   endtask

   task automatic press(input int v);
      btn_val   = CW'(v);
      btn_valid = 1'b1;
      @(negedge clk_tick);
      btn_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_tick);
      n_checks++;
      if ({state, led, error_led, win_led, round, lfsr_enable} !== '0) begin
         n_fail++;
         $display("FAIL reset: state=%0d led=%b err=%b win=%b round=%0d lfsr=%b, want all 0",
                  state, led, error_led, win_led, round, lfsr_enable);
      end
      reset_n = 1'b1;
   endtask

   // Starts on the first INIT cycle; ends on the first WAIT cycle of round 1.
   task automatic test_load(input string nm);
      int cnt, pul, d;
      cnt = 0; pul = 0;
      load_seq(rptr);
      while (state === 3'd0 && cnt < 20) begin
         cnt++;
         if (lfsr_enable === 1'b1) pul++;
         @(negedge clk_tick);
      end
      n_checks++;
      if (cnt != ML + 1) begin
         n_fail++; $display("FAIL %s_init_len: got %0d cycles, want %0d", nm, cnt, ML + 1);
      end
      n_checks++;
      if (pul != ML) begin
         n_fail++; $display("FAIL %s_lfsr_pulses: got %0d, want %0d", nm, pul, ML);
      end
      build_exp(1);
      capture(STEP, 1'b0);
      d = trace_diff();
      n_checks++;
      if (d != -1) begin
         n_fail++; $display("FAIL %s_playback: step %0d led=%b want %b", nm, d, cap_q[d], exp_q[d]);
      end
      n_checks++;
      if (state !== 3'd3 || round !== RW'(1)) begin
         n_fail++; $display("FAIL %s_wait: state=%0d round=%0d, want 3/1", nm, state, round);
      end
   endtask

   task automatic test_error();
      int d, wrong;
      press(seq[0]);
      build_exp(2);
      capture(2 * STEP, 1'b1);
      d = trace_diff();
      n_checks++;
      if (d != -1) begin
         n_fail++; $display("FAIL err_r2_playback: step %0d led=%b want %b", d, cap_q[d], exp_q[d]);
      end
      press(seq[0]);
      n_checks++;
      if (state !== 3'd3 || round !== RW'(2)) begin
         n_fail++; $display("FAIL err_partial: state=%0d round=%0d, want 3/2", state, round);
      end
      wrong = (seq[1] + 1) % NC;
      press(wrong);
      n_checks++;
      if (state !== 3'd4 || error_led !== 1'b1) begin
         n_fail++; $display("FAIL err_enter: state=%0d err=%b, want 4/1", state, error_led);
      end
      repeat (5) @(negedge clk_tick);
      n_checks++;
      if (state !== 3'd4 || error_led !== 1'b1) begin
         n_fail++; $display("FAIL err_hold: state=%0d err=%b, want 4/1", state, error_led);
      end
      press($urandom_range(0, NC - 1));
      n_checks++;
      if (state !== 3'd1 || error_led !== 1'b0 || round !== RW'(1) || led !== NC'(1 << seq[0])) begin
         n_fail++; $display("FAIL err_exit: state=%0d err=%b round=%0d led=%b, want 1/0/1/%b",
                            state, error_led, round, led, NC'(1 << seq[0]));
      end
      build_exp(1);
      capture(STEP, 1'b0);
      d = trace_diff();
      n_checks++;
      if (d != -1 || state !== 3'd3) begin
         n_fail++; $display("FAIL err_replay: step %0d state=%0d, want trace match and state 3", d, state);
      end
   endtask

   task automatic test_play_to_win();
      int d;
      for (int r = 1; r <= ML; r++) begin
         for (int i = 0; i < r; i++) begin
            press(seq[i]);
            if (i < r - 1) begin
               n_checks++;
               if (state !== 3'd3 || round !== RW'(r)) begin
                  n_fail++; $display("FAIL play_r%0d_press%0d: state=%0d round=%0d, want 3/%0d",
                                     r, i, state, round, r);
               end
            end
         end
         if (r < ML) begin
            build_exp(r + 1);
            capture((r + 1) * STEP, 1'b1);
            d = trace_diff();
            n_checks++;
            if (d != -1) begin
               n_fail++; $display("FAIL play_r%0d_playback: step %0d led=%b want %b",
                                  r + 1, d, cap_q[d], exp_q[d]);
            end
            n_checks++;
            if (state !== 3'd3 || round !== RW'(r + 1)) begin
               n_fail++; $display("FAIL play_r%0d_wait: state=%0d round=%0d", r + 1, state, round);
            end
         end
      end
      n_checks++;
      if (state !== 3'd5 || win_led !== 1'b1 || led !== '0 || round !== RW'(ML)) begin
         n_fail++; $display("FAIL win_enter: state=%0d win=%b led=%b round=%0d, want 5/1/0/%0d",
                            state, win_led, led, round, ML);
      end
   endtask

   task automatic test_win_restart();
      repeat (4) @(negedge clk_tick);
      n_checks++;
      if (state !== 3'd5 || win_led !== 1'b1) begin
         n_fail++; $display("FAIL win_hold: state=%0d win=%b, want 5/1", state, win_led);
      end
      press($urandom_range(0, NC - 1));
      n_checks++;
      if (state !== 3'd0 || win_led !== 1'b0 || round !== '0) begin
         n_fail++; $display("FAIL win_exit: state=%0d win=%b round=%0d, want 0/0/0",
                            state, win_led, round);
      end
      test_load("reload");
   endtask

   task automatic test_wait_timeout();
`ifdef SIMON_TIMEOUT_EN
      int d;
      repeat (TO - 1) @(negedge clk_tick);
      n_checks++;
      if (state !== 3'd3 || error_led !== 1'b0) begin
         n_fail++; $display("FAIL to_early: state=%0d err=%b, want 3/0", state, error_led);
      end
      press(seq[0]);
      n_checks++;
      if (state !== 3'd1 || round !== RW'(2) || error_led !== 1'b0) begin
         n_fail++; $display("FAIL to_last_cycle_press: state=%0d round=%0d err=%b, want 1/2/0",
                            state, round, error_led);
      end
      build_exp(2);
      capture(2 * STEP, 1'b0);
      d = trace_diff();
      n_checks++;
      if (d != -1) begin
         n_fail++; $display("FAIL to_r2_playback: step %0d led=%b want %b", d, cap_q[d], exp_q[d]);
      end
      repeat (TO - 1) @(negedge clk_tick);
      n_checks++;
      if (state !== 3'd3 || error_led !== 1'b0) begin
         n_fail++; $display("FAIL to_before: state=%0d err=%b, want 3/0", state, error_led);
      end
      @(negedge clk_tick);
      n_checks++;
      if (state !== 3'd4 || error_led !== 1'b1) begin
         n_fail++; $display("FAIL to_expire: state=%0d err=%b, want 4/1", state, error_led);
      end
      press($urandom_range(0, NC - 1));
      capture(STEP, 1'b0);
      n_checks++;
      if (state !== 3'd3 || round !== RW'(1)) begin
         n_fail++; $display("FAIL to_recover: state=%0d round=%0d, want 3/1", state, round);
      end
`else
      repeat (60) @(negedge clk_tick);
      n_checks++;
      if (state !== 3'd3 || error_led !== 1'b0 || round !== RW'(1)) begin
         n_fail++; $display("FAIL wait_forever: state=%0d err=%b round=%0d, want 3/0/1",
                            state, error_led, round);
      end
`endif
   endtask

   task automatic test_async_reset();
      press(seq[0]);
      capture(2 * STEP, 1'b0);
      n_checks++;
      if (state !== 3'd3 || round !== RW'(2)) begin
         n_fail++; $display("FAIL ar_setup: state=%0d round=%0d, want 3/2", state, round);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({state, led, error_led, win_led, round, lfsr_enable} !== '0) begin
         n_fail++; $display("FAIL async_reset: state=%0d led=%b err=%b win=%b round=%0d lfsr=%b, want all 0",
                            state, led, error_led, win_led, round, lfsr_enable);
      end
      @(negedge clk_tick);
      reset_n = 1'b1;
      test_load("after_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rq[i] = CW'($urandom_range(0, NC - 1));
      rq[0] = 2'd2; rq[1] = 2'd0; rq[2] = 2'd3; rq[3] = 2'd1;
      rnd_val = rq[0];
      test_reset();
      test_load("load");
      test_error();
      test_play_to_win();
      test_win_restart();
      test_wait_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
